rom_load_sequencer: RTL and testbench

- Sits between hps_io's ROM download port and the game core (Tankb_fpga) ROM/PROM write ports.
- Decodes the linear download stream into three target regions: program ROM, graphics ROM and colour PROM.
- Paces writes against a target-busy handshake using a one-entry buffer.
- Sequences the core reset around the download and reports completion, byte count and error status.

---
 rtl/rom_load_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// Routes the hps_io ROM download stream into program ROM, graphics ROM and colour PROM,
// pacing writes through a one-entry buffer and holding the core in reset around the load.
module rom_load_sequencer #(
    parameter logic [15:0] PROG_SIZE = 16'h2000,
    parameter logic [15:0] GFX_SIZE  = 16'h0800,
    parameter logic [15:0] PROM_SIZE = 16'h0100,
    parameter int          RST_HOLD  = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [13:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    input  logic        tgt_busy,
    output logic        prog_we,
    output logic        gfx_we,
    output logic        prom_we,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        core_reset_n,
    output logic        load_done,
    output logic        load_err,
    output logic [14:0] byte_count
);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] REG_PROG = 2'd0;
    localparam logic [1:0] REG_GFX  = 2'd1;
    localparam logic [1:0] REG_PROM = 2'd2;
    localparam logic [1:0] REG_NONE = 2'd3;

    localparam logic [15:0] GFX_BASE  = PROG_SIZE;
    localparam logic [15:0] PROM_BASE = PROG_SIZE + GFX_SIZE;
    localparam logic [15:0] TOTAL     = PROG_SIZE + GFX_SIZE + PROM_SIZE;
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    function automatic logic [1:0] region_of(input logic [13:0] a);
        logic [15:0] a16;
        a16 = {2'b00, a};
        if (a16 < GFX_BASE)       region_of = REG_PROG;
        else if (a16 < PROM_BASE) region_of = REG_GFX;
        else if (a16 < TOTAL)     region_of = REG_PROM;
        else                      region_of = REG_NONE;
    endfunction

    function automatic logic [13:0] rel_addr(input logic [13:0] a);
        logic [15:0] a16;
        a16 = {2'b00, a};
        case (region_of(a))
            REG_PROG: rel_addr = a;
            REG_GFX:  rel_addr = 14'(a16 - GFX_BASE);
            REG_PROM: rel_addr = 14'(a16 - PROM_BASE);
            default:  rel_addr = 14'd0;
        endcase
    endfunction

    function automatic logic [14:0] sat_inc(input logic [14:0] c);
        sat_inc = (c == 15'h7FFF) ? c : c + 15'd1;
    endfunction

    logic [1:0]  state_q,      state_d;
    logic [15:0] hold_cnt_q,   hold_cnt_d;
    logic        dl_active_q,  dl_active_d;
    logic        buf_full_q,   buf_full_d;
    logic [13:0] buf_addr_q,   buf_addr_d;
    logic [7:0]  buf_data_q,   buf_data_d;
    logic [14:0] byte_count_q, byte_count_d;
    logic        load_done_q,  load_done_d;
    logic        load_err_q,   load_err_d;

    logic        drain_now;
    logic        wr_fire;
    logic        dl_rise;
    logic        dl_fall;
    logic        accept;
    logic        drop;
    logic        short_load;
    logic [1:0]  buf_region;

    assign drain_now  = buf_full_q & ~tgt_busy;
    // Gate with reset so a buffered byte is never written while reset is being applied.
    assign wr_fire    = drain_now & ~reset;
    assign buf_region = region_of(buf_addr_q);
    assign dl_rise    = dl_active & ~dl_active_q;
    assign dl_fall    = ~dl_active & dl_active_q;
    assign accept     = (state_q == ST_LOAD) & dl_wr & (~buf_full_q | drain_now);
    assign drop       = (state_q == ST_LOAD) & dl_wr & buf_full_q & ~drain_now;
    assign short_load = ({1'b0, byte_count_q} < TOTAL);

    assign prog_we      = wr_fire & (buf_region == REG_PROG);
    assign gfx_we       = wr_fire & (buf_region == REG_GFX);
    assign prom_we      = wr_fire & (buf_region == REG_PROM);
    assign wr_addr      = rel_addr(buf_addr_q);
    assign wr_data      = buf_data_q;
    assign dl_wait      = buf_full_q & tgt_busy;
    assign core_reset_n = (state_q == ST_RUN);
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign byte_count   = byte_count_q;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        dl_active_d  = dl_active;
        buf_full_d   = buf_full_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        byte_count_d = byte_count_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        if (drain_now) begin
            buf_full_d = 1'b0;
        end
        // A write arriving on the drain cycle refills the buffer with no bubble.
        if (accept) begin
            buf_full_d   = 1'b1;
            buf_addr_d   = dl_addr;
            buf_data_d   = dl_data;
            byte_count_d = sat_inc(byte_count_q);
            if (region_of(dl_addr) == REG_NONE) begin
                load_err_d = 1'b1;
            end
        end
        if (drop) begin
            load_err_d = 1'b1;
        end

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 16'd1;
                if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = ST_RUN;
                end
                if (dl_rise) begin
                    state_d      = ST_LOAD;
                    byte_count_d = 15'd0;
                    load_done_d  = 1'b0;
                    load_err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (dl_rise) begin
                    state_d      = ST_LOAD;
                    byte_count_d = 15'd0;
                    load_done_d  = 1'b0;
                    load_err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (dl_fall) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the pending byte to leave before judging the load.
                if (!buf_full_q) begin
                    load_err_d  = load_err_q | short_load;
                    load_done_d = ~(load_err_q | short_load);
                    hold_cnt_d  = 16'd0;
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= 16'd0;
            dl_active_q  <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_addr_q   <= 14'd0;
            buf_data_q   <= 8'd0;
            byte_count_q <= 15'd0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            dl_active_q  <= dl_active_d;
            buf_full_q   <= buf_full_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            byte_count_q <= byte_count_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: full load, stalls, drops, short/out-of-range loads, reset.
module tb_rom_load_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [13:0] dl_addr = 14'd0;
    logic [7:0]  dl_data = 8'd0;
    logic        dl_wait;
    logic        tgt_busy = 1'b0;
    logic        prog_we, gfx_we, prom_we;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        core_reset_n, load_done, load_err;
    logic [14:0] byte_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Write-port monitor state (only the monitor process writes these).
    int prog_n = 0, gfx_n = 0, prom_n = 0, multi_n = 0, data_bad = 0, order_bad = 0;
    int last_glob = -1;
    int gfx_first = -1, prom_first = -1, prog_last = -1;

    rom_load_sequencer dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .tgt_busy(tgt_busy),
        .prog_we(prog_we), .gfx_we(gfx_we), .prom_we(prom_we), .wr_addr(wr_addr),
        .wr_data(wr_data), .core_reset_n(core_reset_n), .load_done(load_done),
        .load_err(load_err), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + a / 256 + 3);
    endfunction

    always @(negedge clk_sys) begin
        int we_sum;
        int glob;
        we_sum = int'(prog_we) + int'(gfx_we) + int'(prom_we);
        if (we_sum > 1) multi_n++;
        if (we_sum == 1) begin
            if (prog_we) begin
                glob = int'(wr_addr);
                prog_n++;
                prog_last = glob;
            end else if (gfx_we) begin
                glob = int'(wr_addr) + 32'h2000;
                gfx_n++;
                if (gfx_first < 0) gfx_first = int'(wr_addr);
            end else begin
                glob = int'(wr_addr) + 32'h2800;
                prom_n++;
                if (prom_first < 0) prom_first = int'(wr_addr);
            end
            if (wr_data !== pat(glob)) data_bad++;
            if (glob != last_glob + 1) order_bad++;
            last_glob = glob;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!core_reset_n && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic send_byte(input int a);
        dl_wr   = 1'b1;
        dl_addr = 14'(a);
        dl_data = pat(a);
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        tick();
        tick();
    endtask

    // Load bytes 0..5, stall the target for five cycles, optionally try a write mid-stall.
    task automatic stall_test(input bit with_drop);
        int p0, n;
        string sfx;
        sfx = with_drop ? "_drop" : "";
        p0 = prog_n;
        start_dl();
        for (int i = 0; i < 6; i++) send_byte(i);
        tgt_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (with_drop && i == 2) begin
                dl_wr   = 1'b1;
                dl_addr = 14'd6;
                dl_data = pat(6);
            end
            @(negedge clk_sys);
            check({"stall_wait", sfx}, dl_wait, 1);
            check({"stall_no_we", sfx}, prog_we, 0);
            tick();
            dl_wr = 1'b0;
        end
        tgt_busy = 1'b0;
        @(negedge clk_sys);
        check({"release_we", sfx}, prog_we, 1);
        check({"release_addr", sfx}, wr_addr, 5);
        check({"release_data", sfx}, wr_data, pat(5));
        check({"release_wait", sfx}, dl_wait, 0);
        check({"core_in_reset", sfx}, core_reset_n, 0);
        tick();
        check({"err_after_stall", sfx}, load_err, with_drop ? 1 : 0);
        check({"prog_pulses", sfx}, prog_n - p0, 6);
        end_dl();
        check({"stall_count", sfx}, byte_count, 6);
        check({"stall_done", sfx}, load_done, 0);
        check({"stall_err", sfx}, load_err, 1);
        wait_run(n);
        check({"stall_hold", sfx}, n, 16);
    endtask

    initial begin
        int n, p0, g0, r0, ob0, db0, m0;

        // Reset and power-on hold
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_core_reset_n", core_reset_n, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_we", {prog_we, gfx_we, prom_we}, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        wait_run(n);
        check("rst_hold_cycles", n, 16);
        check("rst_done_after", load_done, 0);

        // Complete download of all three regions
        p0 = prog_n; g0 = gfx_n; r0 = prom_n; ob0 = order_bad; db0 = data_bad; m0 = multi_n;
        start_dl();
        check("load_core_reset", core_reset_n, 0);
        check("load_count_cleared", byte_count, 0);
        for (int a = 0; a < 32'h2900; a++) send_byte(a);
        end_dl();
        check("full_prog_n", prog_n - p0, 32'h2000);
        check("full_gfx_n", gfx_n - g0, 32'h0800);
        check("full_prom_n", prom_n - r0, 32'h0100);
        check("full_prog_last", prog_last, 32'h1FFF);
        check("full_gfx_first", gfx_first, 0);
        check("full_prom_first", prom_first, 0);
        check("full_order", order_bad - ob0, 0);
        check("full_data", data_bad - db0, 0);
        check("full_multi_we", multi_n - m0, 0);
        check("full_byte_count", byte_count, 32'h2900);
        check("full_done", load_done, 1);
        check("full_err", load_err, 0);
        check("full_core_reset", core_reset_n, 0);
        wait_run(n);
        check("full_hold_cycles", n, 16);

        // Target stall, then stall with a dropped byte
        stall_test(1'b0);
        stall_test(1'b1);

        // Short download: program ROM only
        p0 = prog_n; g0 = gfx_n;
        start_dl();
        for (int a = 0; a < 32'h2000; a++) send_byte(a);
        end_dl();
        check("short_prog_n", prog_n - p0, 32'h2000);
        check("short_gfx_n", gfx_n - g0, 0);
        check("short_count", byte_count, 32'h2000);
        check("short_err", load_err, 1);
        check("short_done", load_done, 0);
        wait_run(n);
        check("short_hold", n, 16);

        // Single byte beyond the colour PROM
        p0 = prog_n + gfx_n + prom_n;
        start_dl();
        send_byte(32'h2900);
        tick();
        check("oor_err_now", load_err, 1);
        check("oor_count", byte_count, 1);
        check("oor_no_we", prog_n + gfx_n + prom_n - p0, 0);
        end_dl();
        check("oor_done", load_done, 0);
        wait_run(n);
        check("oor_hold", n, 16);

        // Reset while a byte is buffered and the target is busy
        p0 = prog_n + gfx_n + prom_n;
        start_dl();
        send_byte(3);
        tgt_busy = 1'b1;
        reset    = 1'b1;
        @(negedge clk_sys);
        check("mid_rst_wait_before", dl_wait, 1);
        tick();
        reset     = 1'b0;
        tgt_busy  = 1'b0;
        dl_active = 1'b0;
        @(negedge clk_sys);
        check("mid_rst_wait", dl_wait, 0);
        check("mid_rst_count", byte_count, 0);
        check("mid_rst_err", load_err, 0);
        check("mid_rst_core", core_reset_n, 0);
        tick();
        tick();
        check("mid_rst_no_we", prog_n + gfx_n + prom_n - p0, 0);
        wait_run(n);
        check("mid_rst_hold", n, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
